// File: rtl/register_file_32x32.sv
`default_nettype none
// ============================================================================
// Module      : register_file_32x32
// Description : 32 x 32-bit register file, one write port, two registered
//               read ports with read-before-write on a shared address.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  C,
    input  logic                  nR,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic                  READ,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [c_DEPTH-1:0]    w_load;
    logic [DATA_WIDTH-1:0] w_words [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_r1;
    logic [DATA_WIDTH-1:0] r_data_r2;

    // 5-to-32 write decoder: at most one load enable is active
    always_comb begin
        w_load = '0;
        if (WRITE) begin
            w_load[ADDR_W] = 1'b1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < c_DEPTH; i++) begin : g_reg
            logic [DATA_WIDTH-1:0] r_q;

            always_ff @(posedge C or negedge nR) begin
                if (!nR) begin
                    r_q <= '0;
                end else if (w_load[i]) begin
                    r_q <= DATA_W;
                end
            end

            assign w_words[i] = r_q;
        end
    endgenerate

    // Output registers sample pre-edge storage, giving read-before-write
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            r_data_r1 <= '0;
            r_data_r2 <= '0;
        end else if (READ) begin
            r_data_r1 <= w_words[ADDR_R1];
            r_data_r2 <= w_words[ADDR_R2];
        end
    end

    assign DATA_R1 = r_data_r1;
    assign DATA_R2 = r_data_r2;

endmodule
`default_nettype wire

// File: tb/tb_register_file_32x32.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_32x32
// Description : Directed, table-driven self-checking bench for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_32x32;

    logic        C;
    logic        nR;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic        WRITE;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic        READ;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  aw;
        logic [31:0] dw;
        logic        rd;
        logic [4:0]  ar1;
        logic [4:0]  ar2;
        logic [31:0] e1;
        logic [31:0] e2;
        string       name;
    } vec_t;

    vec_t vecs[$];

    register_file_32x32 #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .C       (C),
        .nR      (nR),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .WRITE   (WRITE),
        .ADDR_R1 (ADDR_R1),
        .ADDR_R2 (ADDR_R2),
        .READ    (READ),
        .DATA_R1 (DATA_R1),
        .DATA_R2 (DATA_R2)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    function automatic vec_t mk(input logic wr, input logic [4:0] aw, input logic [31:0] dw,
                                input logic rd, input logic [4:0] ar1, input logic [4:0] ar2,
                                input logic [31:0] e1, input logic [31:0] e2, input string name);
        vec_t v;
        v.wr = wr; v.aw = aw; v.dw = dw; v.rd = rd; v.ar1 = ar1; v.ar2 = ar2;
        v.e1 = e1; v.e2 = e2; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got1, input logic [31:0] got2,
                         input logic [31:0] exp1, input logic [31:0] exp2);
        n_checks++;
        if (got1 !== exp1 || got2 !== exp2) begin
            n_fail++;
            $display("FAIL %s: DATA_R1=%h DATA_R2=%h, expected %h %h", name, got1, got2, exp1, exp2);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge C);
        WRITE   = v.wr;
        ADDR_W  = v.aw;
        DATA_W  = v.dw;
        READ    = v.rd;
        ADDR_R1 = v.ar1;
        ADDR_R2 = v.ar2;
        @(posedge C);
        #1;
        check(v.name, DATA_R1, DATA_R2, v.e1, v.e2);
    endtask

    initial begin
        // Post-reset reads
        vecs.push_back(mk(0, 0, 0, 1, 5'd0,  5'd17, 32'h0, 32'h0, "rst_rd_0_17"));
        vecs.push_back(mk(0, 0, 0, 1, 5'd31, 5'd31, 32'h0, 32'h0, "rst_rd_31"));
        // Fill: no read, outputs hold 0
        for (int i = 0; i < 32; i++)
            vecs.push_back(mk(1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 5'd0, 32'h0, 32'h0, "fill"));
        // Read all, crossed addresses
        for (int i = 0; i < 32; i++)
            vecs.push_back(mk(0, 0, 0, 1, 5'(i), 5'(31 - i),
                              32'h100 + 32'(i), 32'h100 + 32'(31 - i), "rd_all"));
        // Same-edge hazard on address 5
        vecs.push_back(mk(1, 5'd5, 32'hAAAA_AAAA, 0, 5'd0, 5'd0, 32'h11F, 32'h100, "hz_prep"));
        vecs.push_back(mk(1, 5'd5, 32'h5555_5555, 1, 5'd5, 5'd6, 32'hAAAA_AAAA, 32'h106, "hz_same_edge"));
        vecs.push_back(mk(0, 0, 0, 1, 5'd5, 5'd5, 32'h5555_5555, 32'h5555_5555, "hz_next"));
        // Hold with READ=0 while address sweeps
        vecs.push_back(mk(0, 0, 0, 0, 5'd0,  5'd1,  32'h5555_5555, 32'h5555_5555, "hold_a0"));
        vecs.push_back(mk(0, 0, 0, 0, 5'd8,  5'd2,  32'h5555_5555, 32'h5555_5555, "hold_a8"));
        vecs.push_back(mk(0, 0, 0, 0, 5'd16, 5'd3,  32'h5555_5555, 32'h5555_5555, "hold_a16"));
        vecs.push_back(mk(0, 0, 0, 0, 5'd31, 5'd4,  32'h5555_5555, 32'h5555_5555, "hold_a31"));
        // WRITE=0 must not store
        vecs.push_back(mk(0, 5'd10, 32'hFFFF_FFFF, 0, 5'd0, 5'd0, 32'h5555_5555, 32'h5555_5555, "nowr"));
        vecs.push_back(mk(0, 0, 0, 1, 5'd10, 5'd5, 32'h10A, 32'h5555_5555, "nowr_rd"));
        // Dual-port same address, register 0 writable
        vecs.push_back(mk(1, 5'd9, 32'd3, 0, 5'd0, 5'd0, 32'h10A, 32'h5555_5555, "wr9"));
        vecs.push_back(mk(0, 0, 0, 1, 5'd9, 5'd9, 32'd3, 32'd3, "dual9"));
        vecs.push_back(mk(1, 5'd0, 32'd7, 0, 5'd0, 5'd0, 32'd3, 32'd3, "wr0"));
        vecs.push_back(mk(0, 0, 0, 1, 5'd0, 5'd9, 32'd7, 32'd3, "rd0"));

        nR = 1'b1; WRITE = 0; READ = 0; ADDR_W = 0; ADDR_R1 = 0; ADDR_R2 = 0; DATA_W = 0;
        #2 nR = 1'b0;
        // Reset held with active strobes
        for (int k = 0; k < 3; k++) begin
            @(negedge C);
            WRITE = 1'b1; READ = 1'b1; DATA_W = $urandom;
            ADDR_W = 5'($urandom_range(0, 31)); ADDR_R1 = ADDR_W; ADDR_R2 = 5'd17;
            @(posedge C);
            #1;
            check("rst_held", DATA_R1, DATA_R2, 32'h0, 32'h0);
        end
        @(negedge C);
        WRITE = 0; READ = 0;
        nR = 1'b1;

        foreach (vecs[k]) apply(vecs[k]);

        // Asynchronous reset between edges, then with strobes active across an edge
        @(posedge C);
        #3;
        nR = 1'b0;
        #1;
        check("async_rst", DATA_R1, DATA_R2, 32'h0, 32'h0);
        WRITE = 1'b1; ADDR_W = 5'd12; DATA_W = 32'hDEAD_BEEF; READ = 1'b1;
        @(posedge C);
        #1;
        check("rst_wins", DATA_R1, DATA_R2, 32'h0, 32'h0);
        @(negedge C);
        WRITE = 1'b0; READ = 1'b0;
        nR = 1'b1;
        for (int i = 0; i < 32; i++)
            apply(mk(0, 0, 0, 1, 5'(i), 5'(31 - i), 32'h0, 32'h0, "post_rst_rd"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
